// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Shared FSM states, exception codes and size encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DM_ACC   = 2'd1,
        DEV_WAIT = 2'd2,
        RESP     = 2'd3
    } state_t;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Size 3 is reserved and behaves as a word access.
    function automatic logic isWordSize(input logic [1:0] size);
        return size[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_if
// Description : Request, DM, device and response signals of the memory stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if #(
    parameter int N_DEV = 2
);
    logic                   req_valid;
    logic                   req_load;
    logic                   req_store;
    logic [1:0]             req_size;
    logic                   req_signed;
    logic [31:0]            req_addr;
    logic [31:0]            req_wdata;
    logic [4:0]             in_exc;
    logic                   flush;
    logic                   dm_we;
    logic [3:0]             dm_be;
    logic [31:0]            dm_addr;
    logic [31:0]            dm_wdata;
    logic [31:0]            dm_rdata;
    logic [N_DEV-1:0]       dev_req;
    logic                   dev_we;
    logic [31:0]            dev_addr;
    logic [31:0]            dev_wdata;
    logic [32*N_DEV-1:0]    dev_rdata;
    logic [N_DEV-1:0]       dev_ack;
    logic                   stall;
    logic                   resp_valid;
    logic [31:0]            resp_rdata;
    logic [4:0]             resp_exc;

    modport master (
        output req_valid, req_load, req_store, req_size, req_signed, req_addr,
               req_wdata, in_exc, flush, dm_rdata, dev_rdata, dev_ack,
        input  dm_we, dm_be, dm_addr, dm_wdata, dev_req, dev_we, dev_addr,
               dev_wdata, stall, resp_valid, resp_rdata, resp_exc
    );

    modport slave (
        input  req_valid, req_load, req_store, req_size, req_signed, req_addr,
               req_wdata, in_exc, flush, dm_rdata, dev_rdata, dev_ack,
        output dm_we, dm_be, dm_addr, dm_wdata, dev_req, dev_we, dev_addr,
               dev_wdata, stall, resp_valid, resp_rdata, resp_exc
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit_addr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_addr_decoder
// Description : Decodes a byte address into DM / device window hits.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit_addr_decoder #(
    parameter int          N_DEV      = 2,
    parameter logic [31:0] DM_TOP     = 32'h0000_2fff,
    parameter logic [31:0] DEV_BASE   = 32'h0000_7f00,
    parameter logic [31:0] DEV_STRIDE = 32'h10,
    parameter int          DEV_SPAN   = 12,
    parameter int          RO_WORD    = 2
) (
    input  wire logic [31:0]      i_addr,
    output logic                  o_hitDm,
    output logic [N_DEV-1:0]      o_hitDev,
    output logic                  o_roHit
);
    logic [N_DEV-1:0] w_roDev;

    assign o_hitDm = (i_addr <= DM_TOP);

    for (genvar k = 0; k < N_DEV; k++) begin : g_dev
        localparam logic [31:0] c_BASE = DEV_BASE + DEV_STRIDE * k;
        logic [31:0] w_off;

        // The lower-bound test keeps the wrapped offset from aliasing a hit.
        assign w_off       = i_addr - c_BASE;
        assign o_hitDev[k] = (i_addr >= c_BASE) && (w_off < 32'(DEV_SPAN));
        assign w_roDev[k]  = o_hitDev[k] && (w_off[31:2] == 30'(RO_WORD));
    end

    assign o_roHit = |w_roDev;

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Memory-stage access FSM: decode, DM access, device req/ack.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int          N_DEV      = 2,
    parameter logic [31:0] DM_TOP     = 32'h0000_2fff,
    parameter logic [31:0] DEV_BASE   = 32'h0000_7f00,
    parameter logic [31:0] DEV_STRIDE = 32'h10,
    parameter int          DEV_SPAN   = 12,
    parameter int          RO_WORD    = 2,
    parameter int          TIMEOUT    = 16
) (
    input  wire logic        clk,
    input  wire logic        reset,
    mem_access_unit_if.slave bus
);
    localparam int c_CNT_W = $clog2(TIMEOUT);
    localparam int c_IDX_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;

    state_t               r_state, w_nextState;
    logic                 r_store, r_signed, r_kill;
    logic [1:0]           r_size;
    logic [31:0]          r_addr, r_wdata, r_rdata;
    logic [4:0]           r_exc;
    logic [c_IDX_W-1:0]   r_devIdx;
    logic [c_CNT_W-1:0]   r_cnt;

    logic                 w_hitDm, w_roHit, w_anyDev, w_wordSize, w_misalign, w_badAddr;
    logic [N_DEV-1:0]     w_hitDev;
    logic                 w_accept, w_devAck, w_timeout;
    logic [4:0]           w_exc;
    logic [c_IDX_W-1:0]   w_devIdx;
    logic [3:0]           w_dmBe;
    logic [31:0]          w_dmWdata, w_laneWord, w_loadData;

    mem_access_unit_addr_decoder #(
        .N_DEV(N_DEV), .DM_TOP(DM_TOP), .DEV_BASE(DEV_BASE),
        .DEV_STRIDE(DEV_STRIDE), .DEV_SPAN(DEV_SPAN), .RO_WORD(RO_WORD)
    ) u_addrDecoder (
        .i_addr   (bus.req_addr),
        .o_hitDm  (w_hitDm),
        .o_hitDev (w_hitDev),
        .o_roHit  (w_roHit)
    );

    // Gated by reset so nothing is stalled while the unit is held in reset.
    assign w_accept   = reset && (r_state == IDLE) && bus.req_valid
                        && (bus.req_load || bus.req_store) && !bus.flush;
    assign w_anyDev   = |w_hitDev;
    assign w_wordSize = isWordSize(bus.req_size);
    assign w_misalign = w_wordSize ? (bus.req_addr[1:0] != 2'b00)
                                   : ((bus.req_size == SIZE_HALF) && bus.req_addr[0]);
    assign w_badAddr  = w_misalign || (w_anyDev && !w_wordSize) || (!w_hitDm && !w_anyDev);

    always_comb begin
        w_exc = EXC_NONE;
        if (bus.in_exc != EXC_NONE)      w_exc = bus.in_exc;
        else if (bus.req_load) begin
            if (w_badAddr)               w_exc = EXC_ADEL;
        end
        else if (w_badAddr || w_roHit)   w_exc = EXC_ADES;
    end

    always_comb begin
        w_devIdx = '0;
        for (int k = 0; k < N_DEV; k++)
            if (w_hitDev[k]) w_devIdx = c_IDX_W'(k);
    end

    always_comb begin
        w_dmBe    = 4'b1111;
        w_dmWdata = r_wdata;
        case (r_size)
            SIZE_BYTE: begin
                w_dmBe    = 4'b0001 << r_addr[1:0];
                w_dmWdata = {4{r_wdata[7:0]}};
            end
            SIZE_HALF: begin
                w_dmBe    = 4'b0011 << r_addr[1:0];
                w_dmWdata = {2{r_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_laneWord = bus.dm_rdata >> {r_addr[1:0], 3'b000};
        w_loadData = bus.dm_rdata;
        case (r_size)
            SIZE_BYTE: w_loadData = {{24{r_signed & w_laneWord[7]}},  w_laneWord[7:0]};
            SIZE_HALF: w_loadData = {{16{r_signed & w_laneWord[15]}}, w_laneWord[15:0]};
            default: ;
        endcase
    end

    assign w_devAck  = bus.dev_ack[r_devIdx];
    assign w_timeout = (r_cnt == c_CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState    = r_state;
        bus.stall      = 1'b0;
        bus.dm_we      = 1'b0;
        bus.dm_be      = 4'b0000;
        bus.dm_addr    = 32'h0;
        bus.dm_wdata   = 32'h0;
        bus.dev_req    = '0;
        bus.dev_we     = 1'b0;
        bus.dev_addr   = 32'h0;
        bus.dev_wdata  = 32'h0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = 32'h0;
        bus.resp_exc   = EXC_NONE;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    bus.stall = 1'b1;
                    if (w_exc != EXC_NONE) w_nextState = RESP;
                    else if (w_anyDev)     w_nextState = DEV_WAIT;
                    else                   w_nextState = DM_ACC;
                end
            end
            DM_ACC: begin
                bus.stall    = 1'b1;
                bus.dm_we    = r_store && !bus.flush;
                bus.dm_be    = w_dmBe;
                bus.dm_addr  = {r_addr[31:2], 2'b00};
                bus.dm_wdata = w_dmWdata;
                w_nextState  = RESP;
            end
            DEV_WAIT: begin
                bus.stall     = 1'b1;
                bus.dev_req   = N_DEV'(1) << r_devIdx;
                bus.dev_we    = r_store;
                bus.dev_addr  = r_addr;
                bus.dev_wdata = r_wdata;
                if (w_devAck || w_timeout) w_nextState = RESP;
            end
            RESP: begin
                bus.resp_valid = !r_kill;
                bus.resp_rdata = r_kill ? 32'h0 : r_rdata;
                bus.resp_exc   = r_kill ? EXC_NONE : r_exc;
                w_nextState    = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_store  <= 1'b0;
            r_signed <= 1'b0;
            r_kill   <= 1'b0;
            r_size   <= SIZE_BYTE;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_rdata  <= 32'h0;
            r_exc    <= EXC_NONE;
            r_devIdx <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_store  <= !bus.req_load;
                    r_signed <= bus.req_signed;
                    r_size   <= bus.req_size;
                    r_addr   <= bus.req_addr;
                    r_wdata  <= bus.req_wdata;
                    r_exc    <= w_exc;
                    r_devIdx <= w_devIdx;
                    r_kill   <= 1'b0;
                    r_rdata  <= 32'h0;
                    r_cnt    <= '0;
                end
                DM_ACC: begin
                    if (!r_store)  r_rdata <= w_loadData;
                    if (bus.flush) r_kill  <= 1'b1;
                end
                DEV_WAIT: begin
                    // A flush here only kills the response; the bus cycle runs to completion.
                    if (bus.flush) r_kill <= 1'b1;
                    if (w_devAck) begin
                        if (!r_store) r_rdata <= bus.dev_rdata[{r_devIdx, 5'b00000} +: 32];
                    end
                    else if (w_timeout) r_exc <= EXC_DBE;
                    else                r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed and randomized checks of mem_access_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_access_unit_if #(.N_DEV(2)) bus ();

    mem_access_unit #(.N_DEV(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int          obLat, obPulses, obStall, obDevCyc, obIdle;
    logic [31:0] obRdata, obDmWdata, obDmAddr;
    logic [4:0]  obExc;
    logic        obDmWe;
    logic [3:0]  obDmBe;
    logic [1:0]  obDevReq;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: window membership by plain address arithmetic.
    function automatic int devOf(input logic [31:0] a);
        int r = -1;
        for (int k = 0; k < 2; k++)
            if (a >= 32'h7f00 + 32'(k * 16) && a < 32'h7f00 + 32'(k * 16) + 32'd12) r = k;
        return r;
    endfunction

    function automatic logic [4:0] modelExc(input logic lo, input logic [1:0] sz,
                                            input logic [31:0] a, input logic [4:0] ie);
        int   k    = devOf(a);
        logic word = (sz >= 2'd2);
        logic mis  = word ? ((a % 4) != 0) : (sz == 2'd1 && (a % 2) != 0);
        logic bad  = mis || (k >= 0 && !word) || (a > 32'h2fff && k < 0);
        logic ro   = (k >= 0) && (((a - 32'h7f00 - 32'(k * 16)) / 4) == 2);
        if (ie != 0) return ie;
        if (lo)      return bad ? 5'd4 : 5'd0;
        return (bad || ro) ? 5'd5 : 5'd0;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [1:0] sz, input logic sg,
                                              input logic [31:0] a, input logic [31:0] d);
        longint v;
        int     sh = 8 * int'(a % 4);
        if (sz >= 2'd2) return d;
        if (sz == 2'd0) begin
            v = longint'((d >> sh) & 32'hff);
            if (sg && v >= 128) v -= 256;
        end else begin
            v = longint'((d >> sh) & 32'hffff);
            if (sg && v >= 32768) v -= 65536;
        end
        return 32'(v);
    endfunction

    // Drives one request from posedge+1 and observes until two idle cycles pass.
    task automatic runTxn(input logic lo, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] inExc, input logic [31:0] dmData,
                          input logic [31:0] devData, input int ackOn, input int flushAt);
        int k = devOf(addr);
        obLat = -1; obPulses = 0; obStall = 0; obDevCyc = 0; obIdle = 0;
        obRdata = 0; obExc = 0; obDmWe = 0; obDmBe = 0; obDmWdata = 0; obDmAddr = 0; obDevReq = 0;
        bus.req_valid = 1'b1; bus.req_load = lo; bus.req_store = !lo;
        bus.req_size = sz; bus.req_signed = sg; bus.req_addr = addr; bus.req_wdata = wdata;
        bus.in_exc = inExc; bus.dm_rdata = dmData;
        bus.dev_rdata = (k == 1) ? {devData, ~devData} : {~devData, devData};
        for (int c = 0; c < 40 && obIdle < 2; c++) begin
            bus.flush   = (c == flushAt);
            bus.dev_ack = 2'b00;
            #1;
            if (bus.dev_req != 2'b00) begin
                obDevCyc++;
                obDevReq = bus.dev_req;
                if (obDevCyc == ackOn) bus.dev_ack = bus.dev_req;
            end
            #1;
            if (bus.stall) obStall++;
            if (bus.dm_we) obDmWe = 1'b1;
            if (bus.dm_be != 4'b0000) begin
                obDmBe = bus.dm_be; obDmWdata = bus.dm_wdata; obDmAddr = bus.dm_addr;
            end
            if (bus.resp_valid) begin
                obPulses++; obLat = c; obRdata = bus.resp_rdata; obExc = bus.resp_exc;
            end
            if (!bus.stall) begin
                obIdle++;
                bus.req_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.flush = 1'b0; bus.dev_ack = 2'b00; bus.req_valid = 1'b0;
        check32("txn_terminates", 32'(obIdle), 32'd2);
    endtask

    task automatic checkTxn(input string tag, input int eLat, input int ePulses,
                            input logic [4:0] eExc, input logic [31:0] eRdata,
                            input int eStall, input int eDevCyc);
        check32({tag, "_latency"}, 32'(obLat), 32'(eLat));
        check32({tag, "_pulses"},  32'(obPulses), 32'(ePulses));
        check32({tag, "_exc"},     32'(obExc), 32'(eExc));
        check32({tag, "_rdata"},   obRdata, eRdata);
        check32({tag, "_stall"},   32'(obStall), 32'(eStall));
        check32({tag, "_devcyc"},  32'(obDevCyc), 32'(eDevCyc));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        lo, sg;
        logic [1:0]  sz;
        logic [31:0] addr, wdata, dmData, devData, eRdata;
        logic [4:0]  inExc, eExc;
        int          ackOn, eLat, eDev, k;

        reset = 1'b0;
        bus.req_valid = 0; bus.req_load = 0; bus.req_store = 0; bus.req_size = 0;
        bus.req_signed = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.in_exc = 0;
        bus.flush = 0; bus.dm_rdata = 0; bus.dev_rdata = 0; bus.dev_ack = 0;
        repeat (3) @(posedge clk);
        #1;
        check32("rst_stall",      32'(bus.stall), 0);
        check32("rst_dm_we",      32'(bus.dm_we), 0);
        check32("rst_dm_be",      32'(bus.dm_be), 0);
        check32("rst_dm_addr",    bus.dm_addr, 0);
        check32("rst_dev_req",    32'(bus.dev_req), 0);
        check32("rst_resp_valid", 32'(bus.resp_valid), 0);
        check32("rst_resp_rdata", bus.resp_rdata, 0);
        check32("rst_resp_exc",   32'(bus.resp_exc), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        runTxn(1, 2, 0, 32'h100, 0, 0, 32'h8899AABB, 0, 0, -1);
        checkTxn("lw_dm", 2, 1, 0, 32'h8899AABB, 2, 0);
        check32("lw_dm_we", 32'(obDmWe), 0);

        runTxn(1, 0, 1, 32'h103, 0, 0, 32'h80000000, 0, 0, -1);
        checkTxn("lb_signed", 2, 1, 0, 32'hFFFFFF80, 2, 0);
        runTxn(1, 0, 0, 32'h103, 0, 0, 32'h80000000, 0, 0, -1);
        checkTxn("lbu", 2, 1, 0, 32'h00000080, 2, 0);

        runTxn(0, 1, 0, 32'h102, 32'h1234, 0, 0, 0, 0, -1);
        checkTxn("sh_dm", 2, 1, 0, 0, 2, 0);
        check32("sh_dm_we",    32'(obDmWe), 1);
        check32("sh_dm_be",    32'(obDmBe), 32'b1100);
        check32("sh_dm_wdata", obDmWdata, 32'h12341234);
        check32("sh_dm_addr",  obDmAddr, 32'h100);

        runTxn(0, 2, 0, 32'h7f18, 32'h55, 0, 0, 0, 1, -1);
        checkTxn("sw_ro", 1, 1, 5, 0, 1, 0);
        runTxn(1, 1, 0, 32'h7f04, 0, 0, 0, 0, 1, -1);
        checkTxn("lh_dev", 1, 1, 4, 0, 1, 0);
        runTxn(1, 2, 0, 32'h3000, 0, 0, 0, 0, 0, -1);
        checkTxn("lw_outside", 1, 1, 4, 0, 1, 0);
        runTxn(1, 2, 0, 32'h100, 0, 5'd3, 32'h1, 0, 0, -1);
        checkTxn("in_exc_pass", 1, 1, 3, 0, 1, 0);

        runTxn(1, 2, 0, 32'h7f04, 0, 0, 0, 32'hCAFE, 0, -1);
        checkTxn("lw_timeout", 17, 1, 7, 0, 17, 16);
        check32("lw_timeout_devreq", 32'(obDevReq), 32'b01);
        runTxn(1, 2, 0, 32'h7f04, 0, 0, 0, 32'hCAFE, 3, -1);
        checkTxn("lw_dev_ack", 4, 1, 0, 32'hCAFE, 4, 3);

        runTxn(0, 2, 0, 32'h200, 32'hDEAD, 0, 0, 0, 0, 1);
        checkTxn("sw_flush_dm", -1, 0, 0, 0, 2, 0);
        check32("sw_flush_dm_we", 32'(obDmWe), 0);
        runTxn(1, 2, 0, 32'h100, 0, 0, 32'h77, 0, 0, 0);
        checkTxn("flush_accept", -1, 0, 0, 0, 0, 0);
        runTxn(1, 2, 0, 32'h7f14, 0, 0, 0, 32'h1357, 4, 2);
        checkTxn("flush_dev", -1, 0, 0, 0, 5, 4);

        // Asynchronous reset while a device access is outstanding.
        bus.req_valid = 1; bus.req_load = 1; bus.req_store = 0; bus.req_size = 2;
        bus.req_addr = 32'h7f04; bus.in_exc = 0; bus.dev_ack = 0;
        repeat (3) @(posedge clk);
        #1;
        check32("pre_reset_devreq", 32'(bus.dev_req), 32'b01);
        #2 reset = 1'b0;
        #1;
        check32("async_rst_devreq", 32'(bus.dev_req), 0);
        check32("async_rst_stall",  32'(bus.stall), 0);
        bus.req_valid = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        runTxn(1, 2, 0, 32'h2ffc, 0, 0, 32'h0BADF00D, 0, 0, -1);
        checkTxn("post_reset_lw", 2, 1, 0, 32'h0BADF00D, 2, 0);

        for (int i = 0; i < 40; i++) begin
            lo = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0, 1: addr = 32'($urandom_range(0, 32'h2fff));
                2:    addr = 32'h7f00 + 32'($urandom_range(0, 1) * 16) + 32'($urandom_range(0, 15));
                3:    addr = 32'h2ff0 + 32'($urandom_range(0, 31));
                default: addr = $urandom;
            endcase
            wdata   = $urandom;
            dmData  = $urandom;
            devData = $urandom;
            inExc   = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            ackOn   = $urandom_range(0, 6);
            runTxn(lo, sz, sg, addr, wdata, inExc, dmData, devData, ackOn, -1);

            k      = devOf(addr);
            eExc   = modelExc(lo, sz, addr, inExc);
            eRdata = 0;
            eDev   = 0;
            if (eExc != 0) eLat = 1;
            else if (k >= 0) begin
                eDev = (ackOn == 0) ? 16 : ackOn;
                eLat = eDev + 1;
                if (ackOn == 0) eExc = 5'd7;
                else if (lo)    eRdata = devData;
            end else begin
                eLat = 2;
                if (lo) eRdata = modelLoad(sz, sg, addr, dmData);
            end
            checkTxn("rand", eLat, 1, eExc, eRdata, eLat, eDev);
            if (eExc == 0 && k < 0) begin
                check32("rand_dm_we", 32'(obDmWe), 32'(!lo));
                if (!lo) begin
                    case (sz)
                        2'd0: begin
                            check32("rand_sb_be", 32'(obDmBe), 32'(4'b0001 << (addr % 4)));
                            check32("rand_sb_wd", obDmWdata, {4{wdata[7:0]}});
                        end
                        2'd1: begin
                            check32("rand_sh_be", 32'(obDmBe), 32'(4'b0011 << (addr % 4)));
                            check32("rand_sh_wd", obDmWdata, {2{wdata[15:0]}});
                        end
                        default: begin
                            check32("rand_sw_be", 32'(obDmBe), 32'hF);
                            check32("rand_sw_wd", obDmWdata, wdata);
                        end
                    endcase
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
